muldiv8_seq_ctrl: RTL and testbench

- Sequencer between the TinyTapeout pin-decode logic and the combinational sky130 FA/HA multiply/divide array of tt_um_dlmiles_muldiv8.
- Accepts one operation per valid/ready handshake and drives registered operands to the array.
- Waits a fixed multicycle settling time, then captures the result and presents it under valid/ready backpressure.
- Owns divide-by-zero policy and the ena freeze behaviour.

---
 rtl/muldiv8_pkg.sv | 12 +
 rtl/muldiv8_bypass_detect.sv | 29 ++
 rtl/muldiv8_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_muldiv8_seq_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv8_pkg.sv
// muldiv8_pkg: shared encodings and sizes for the muldiv8 sequencer
package muldiv8_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [7:0] DIV0_QUOT = 8'hFF;
    localparam int         CNT_W     = 4;

endpackage

// File: rtl/muldiv8_bypass_detect.sv
// muldiv8_bypass_detect: trivial-operand detect and result; body exists only when MULDIV8_BYPASS_EN is defined
`ifdef MULDIV8_BYPASS_EN
module muldiv8_bypass_detect
    import muldiv8_pkg::*;
(
    input  logic        i_op,
    input  logic        i_signed,
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic        o_hit,
    output logic        o_div0,
    output logic [15:0] o_data
);
    logic w_b_zero, w_b_one, w_mul_zero;

    // A zero operand or unit divisor/multiplier has a result known without the array
    always_comb begin
        w_b_zero   = i_b == 8'h00;
        w_b_one    = i_b == 8'h01;
        w_mul_zero = i_a == 8'h00 || w_b_zero;
        o_hit      = (i_op == OP_MUL) ? (w_mul_zero || w_b_one) : (w_b_zero || w_b_one);
        o_div0     = i_op == OP_DIV && w_b_zero;
        o_data     = o_div0            ? {i_a, DIV0_QUOT} :
                     (i_op == OP_DIV)  ? {8'h00, i_a} :
                     w_mul_zero        ? 16'h0000 :
                                         {{8{i_signed & i_a[7]}}, i_a};
    end
endmodule
`endif

// File: rtl/muldiv8_seq_ctrl.sv
// muldiv8_seq_ctrl: valid/ready sequencer for the multicycle muldiv8 array; MULDIV8_BYPASS_EN enables the trivial-operand fast path
module muldiv8_seq_ctrl
    import muldiv8_pkg::*;
#(
    parameter int CORE_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_ena,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic        i_in_op,
    input  logic        i_in_signed,
    input  logic [7:0]  i_in_a,
    input  logic [7:0]  i_in_b,
    output logic [7:0]  o_core_a,
    output logic [7:0]  o_core_b,
    output logic        o_core_op,
    output logic        o_core_signed,
    input  logic [15:0] i_core_result,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [15:0] o_out_data,
    output logic        o_out_div0,
    output logic        o_busy
);
    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_load;
    logic [7:0]       r_core_a, r_core_b;
    logic             r_core_op, r_core_signed, r_out_valid, r_out_div0;
    logic [15:0]      r_out_data, w_cap_data, w_arr_data;
    logic             w_accept, w_cap_div0, w_arr_div0;

    assign w_accept   = i_in_valid && o_in_ready;
    assign w_arr_div0 = r_core_op == OP_DIV && r_core_b == 8'h00;
    assign w_arr_data = w_arr_div0 ? {r_core_a, DIV0_QUOT} : i_core_result;

`ifdef MULDIV8_BYPASS_EN
    logic        w_hit, w_byp_div0, r_byp, r_byp_div0;
    logic [15:0] w_byp_data, r_byp_data;

    muldiv8_bypass_detect u_bypass (
        .i_op     (i_in_op),
        .i_signed (i_in_signed),
        .i_a      (i_in_a),
        .i_b      (i_in_b),
        .o_hit    (w_hit),
        .o_div0   (w_byp_div0),
        .o_data   (w_byp_data)
    );

    // Hold the fast-path result from accept; a zero count makes WAIT last one cycle so out_valid rises after edge 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byp      <= 1'b0;
            r_byp_div0 <= 1'b0;
            r_byp_data <= 16'h0000;
        end else if (i_ena && w_accept) begin
            r_byp      <= w_hit;
            r_byp_div0 <= w_byp_div0;
            r_byp_data <= w_byp_data;
        end
    end

    assign w_cnt_load = w_hit ? '0 : CNT_W'(CORE_LATENCY - 1);
    assign w_cap_data = r_byp ? r_byp_data : w_arr_data;
    assign w_cap_div0 = r_byp ? r_byp_div0 : w_arr_div0;
`else
    assign w_cnt_load = CNT_W'(CORE_LATENCY - 1);
    assign w_cap_data = w_arr_data;
    assign w_cap_div0 = w_arr_div0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state; a low enable freezes every transition
    always_comb begin
        w_next = r_state;
        if (i_ena) begin
            case (r_state)
                IDLE:    w_next = i_in_valid ? WAIT : IDLE;
                WAIT:    w_next = (r_cnt == '0) ? DONE : WAIT;
                DONE:    w_next = (r_out_valid && i_out_ready) ? IDLE : DONE;
                default: w_next = IDLE;
            endcase
        end
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        o_in_ready = r_state == IDLE && i_ena;
        o_busy     = r_state != IDLE;
    end

    // Operand registers, settle counter and result capture; all hold while i_ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_a      <= 8'h00;
            r_core_b      <= 8'h00;
            r_core_op     <= 1'b0;
            r_core_signed <= 1'b0;
            r_cnt         <= '0;
            r_out_data    <= 16'h0000;
            r_out_div0    <= 1'b0;
            r_out_valid   <= 1'b0;
        end else if (i_ena) begin
            if (w_accept) begin
                r_core_a      <= i_in_a;
                r_core_b      <= i_in_b;
                r_core_op     <= i_in_op;
                r_core_signed <= i_in_signed;
                r_cnt         <= w_cnt_load;
            end else if (r_state == WAIT) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end else begin
                    r_out_data  <= w_cap_data;
                    r_out_div0  <= w_cap_div0;
                    r_out_valid <= 1'b1;
                end
            end else if (r_state == DONE && r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_core_a      = r_core_a;
    assign o_core_b      = r_core_b;
    assign o_core_op     = r_core_op;
    assign o_core_signed = r_core_signed;
    assign o_out_valid   = r_out_valid;
    assign o_out_data    = r_out_data;
    assign o_out_div0    = r_out_div0;

endmodule

// File: tb/tb_muldiv8_seq_ctrl.sv
// tb_muldiv8_seq_ctrl: scoreboard bench for muldiv8_seq_ctrl with a registered behavioural array behind core_*
module tb_muldiv8_seq_ctrl;

`ifdef MULDIV8_BYPASS_EN
    localparam int BYP_LAT = 1;
`else
    localparam int BYP_LAT = 2;
`endif

    typedef struct packed {
        logic [15:0] d;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        ena, in_valid, in_ready, in_op, in_signed, core_op, core_signed;
    logic        out_valid, out_ready, out_div0, busy;
    logic [7:0]  in_a, in_b, core_a, core_b;
    logic [15:0] core_result, out_data;

    logic        ena_b, in_valid_b, in_ready_b, in_op_b, in_signed_b, core_op_b, core_signed_b;
    logic        out_valid_b, out_ready_b, out_div0_b, busy_b;
    logic [7:0]  in_a_b, in_b_b, core_a_b, core_b_b;
    logic [15:0] core_result_b, out_data_b;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    exp_t m_e;

    muldiv8_seq_ctrl #(.CORE_LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .i_ena(ena), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_op(in_op), .i_in_signed(in_signed), .i_in_a(in_a), .i_in_b(in_b),
        .o_core_a(core_a), .o_core_b(core_b), .o_core_op(core_op), .o_core_signed(core_signed),
        .i_core_result(core_result), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_data(out_data), .o_out_div0(out_div0), .o_busy(busy)
    );

    muldiv8_seq_ctrl #(.CORE_LATENCY(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_ena(ena_b), .i_in_valid(in_valid_b), .o_in_ready(in_ready_b),
        .i_in_op(in_op_b), .i_in_signed(in_signed_b), .i_in_a(in_a_b), .i_in_b(in_b_b),
        .o_core_a(core_a_b), .o_core_b(core_b_b), .o_core_op(core_op_b), .o_core_signed(core_signed_b),
        .i_core_result(core_result_b), .o_out_valid(out_valid_b), .i_out_ready(out_ready_b),
        .o_out_data(out_data_b), .o_out_div0(out_div0_b), .o_busy(busy_b)
    );

    // Behavioural array; divide by zero returns junk that the controller must ignore
    function automatic logic [15:0] arr(input logic op, input logic sgn, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] q, r;
        if (!op) return sgn ? 16'($signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b})) : 16'({8'h00, a} * {8'h00, b});
        if (b == 8'h00) return 16'hDEAD;
        q = sgn ? 8'($signed(a) / $signed(b)) : a / b;
        r = sgn ? 8'($signed(a) % $signed(b)) : a % b;
        return {r, q};
    endfunction

    always @(posedge clk) begin
        core_result   <= arr(core_op, core_signed, core_a, core_b);
        core_result_b <= arr(core_op_b, core_signed_b, core_a_b, core_b_b);
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got data=%h div0=%b with nothing expected", out_data, out_div0);
            end else begin
                m_e = sb.pop_front();
                if (out_data !== m_e.d || out_div0 !== m_e.z) begin
                    bad++;
                    $display("FAIL sb_result: got data=%h div0=%b want data=%h div0=%b", out_data, out_div0, m_e.d, m_e.z);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic do_op(input string nm, input logic op, input logic sgn, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] ed, input logic ez, input int lat, input int hold);
        exp_t e;
        int   n;
        e.d = ed;
        e.z = ez;
        sb.push_back(e);
        in_op = op; in_signed = sgn; in_a = a; in_b = b; in_valid = 1'b1;
        chk({nm, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = 8'h5A; in_b = 8'hA5;
        chk({nm, "_busy"}, busy, 1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, n, lat);
        for (int i = 0; i < hold; i++) begin
            chk({nm, "_hold_data"}, out_data, ed);
            chk({nm, "_hold_ready"}, in_ready, 0);
            @(posedge clk); #1;
        end
        chk({nm, "_core_a"}, core_a, a);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_valid_clr"}, out_valid, 0);
        chk({nm, "_idle_ready"}, in_ready, 1);
        chk({nm, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_signed = 1'b0; in_a = 8'h00; in_b = 8'h00; out_ready = 1'b0;
        ena_b = 1'b1; in_valid_b = 1'b0; in_op_b = 1'b0; in_signed_b = 1'b0; in_a_b = 8'h00; in_b_b = 8'h00; out_ready_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_data", out_data, 0);
        chk("rst_div0", out_div0, 0);
        chk("rst_core", {core_a, core_b, core_op, core_signed}, 0);

        do_op("mul_u", 1'b0, 1'b0, 8'd13, 8'd11, 16'h008F, 1'b0, 2, 0);
        do_op("div_u", 1'b1, 1'b0, 8'd200, 8'd7, 16'h041C, 1'b0, 2, 0);
        do_op("div0_u", 1'b1, 1'b0, 8'd55, 8'd0, 16'h37FF, 1'b1, BYP_LAT, 0);
        do_op("div0_s", 1'b1, 1'b1, 8'h80, 8'd0, 16'h80FF, 1'b1, BYP_LAT, 0);
        do_op("div_s", 1'b1, 1'b1, 8'hF9, 8'd2, 16'hFFFD, 1'b0, 2, 0);
        do_op("mul_s_bp", 1'b0, 1'b1, 8'hFD, 8'd5, 16'hFFF1, 1'b0, 2, 10);
        do_op("mul_byp", 1'b0, 1'b0, 8'h7F, 8'd1, 16'h007F, 1'b0, BYP_LAT, 0);

        // Latency 4 instance: freeze three cycles in WAIT, then once more in DONE
        in_op_b = 1'b0; in_a_b = 8'd6; in_b_b = 8'd7; in_valid_b = 1'b1;
        chk("ena_ready0", in_ready_b, 1);
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        @(posedge clk); #1;
        ena_b = 1'b0;
        repeat (3) begin
            chk("ena_frz_ready", in_ready_b, 0);
            @(posedge clk); #1;
            chk("ena_frz_valid", out_valid_b, 0);
            chk("ena_frz_busy", busy_b, 1);
        end
        ena_b = 1'b1;
        n = 4;
        while (!out_valid_b && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ena_latency", n, 7);
        chk("ena_data", out_data_b, 16'h002A);
        chk("ena_div0", out_div0_b, 0);
        ena_b = 1'b0; out_ready_b = 1'b1;
        @(posedge clk); #1;
        chk("ena_done_hold", out_valid_b, 1);
        chk("ena_done_busy", busy_b, 1);
        ena_b = 1'b1;
        @(posedge clk); #1;
        out_ready_b = 1'b0;
        chk("ena_done_clr", out_valid_b, 0);
        chk("ena_done_ready", in_ready_b, 1);

        // Reset mid-WAIT must abort with no result ever presented
        in_op = 1'b1; in_signed = 1'b0; in_a = 8'd100; in_b = 8'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_data", out_data, 0);
        chk("arst_core", {core_a, core_b, core_op, core_signed}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("arst_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("arst_no_result", out_valid, 0);
        end
        out_ready = 1'b0;
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
